// File: rtl/mdu_responder.sv
// Multiply/divide unit beside the E-stage ALU: owns HI/LO and models
// multi-cycle mult/div latency with a countdown that drives busy/done.
module mdu_responder #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDU_Op,
  input  logic [31:0] Src_A,
  input  logic [31:0] Src_B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CW = 16;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]    r_state;
  logic [CW-1:0] r_count;
  logic [2:0]    r_op;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_done;

  logic          w_req;
  logic          w_accept;
  logic          w_mtHi;
  logic          w_mtLo;
  logic          w_commit;
  logic          w_bNz;
  logic          w_divOvf;
  logic [31:0]   w_bSafeU;
  logic [31:0]   w_bSafeS;
  logic [63:0]   w_prodS;
  logic [63:0]   w_prodU;
  logic [31:0]   w_quotS;
  logic [31:0]   w_remS;
  logic [31:0]   w_quotU;
  logic [31:0]   w_remU;
  logic [31:0]   w_resHi;
  logic [31:0]   w_resLo;
  logic          w_write;

  // A flush in the same cycle as a request drops the request entirely.
  assign w_req    = (r_state == S_IDLE) && start && !flush;
  assign w_accept = w_req && (MDU_Op >= OP_MULT) && (MDU_Op <= OP_DIVU);
  assign w_mtHi   = w_req && (MDU_Op == OP_MTHI);
  assign w_mtLo   = w_req && (MDU_Op == OP_MTLO);
  assign w_commit = (r_state == S_RUN) && (r_count == CW'(1));

  assign w_bNz    = (r_b != 32'd0);
  assign w_divOvf = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
  assign w_bSafeU = w_bNz ? r_b : 32'd1;
  assign w_bSafeS = (w_bNz && !w_divOvf) ? r_b : 32'd1;

  assign w_prodS  = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prodU  = {32'd0, r_a} * {32'd0, r_b};
  assign w_quotS  = $signed(r_a) / $signed(w_bSafeS);
  assign w_remS   = $signed(r_a) % $signed(w_bSafeS);
  assign w_quotU  = r_a / w_bSafeU;
  assign w_remU   = r_a % w_bSafeU;

  // Divide by zero still runs the full latency but leaves HI/LO untouched.
  always_comb begin
    w_resHi = r_hi;
    w_resLo = r_lo;
    w_write = 1'b0;
    case (r_op)
      OP_MULT: begin
        w_resHi = w_prodS[63:32];
        w_resLo = w_prodS[31:0];
        w_write = 1'b1;
      end
      OP_MULTU: begin
        w_resHi = w_prodU[63:32];
        w_resLo = w_prodU[31:0];
        w_write = 1'b1;
      end
      OP_DIV: begin
        w_resHi = w_divOvf ? 32'd0 : w_remS;
        w_resLo = w_divOvf ? 32'h8000_0000 : w_quotS;
        w_write = w_bNz;
      end
      OP_DIVU: begin
        w_resHi = w_remU;
        w_resLo = w_quotU;
        w_write = w_bNz;
      end
      default: begin
        w_write = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_op    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_op    <= MDU_Op;
            r_a     <= Src_A;
            r_b     <= Src_B;
            r_count <= (MDU_Op <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          end else if (w_mtHi) begin
            r_hi <= Src_A;
          end else if (w_mtLo) begin
            r_lo <= Src_A;
          end
        end
        S_RUN: begin
          // Commit beats flush: the instruction has already retired.
          if (w_commit) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_done  <= 1'b1;
            if (w_write) begin
              r_hi <= w_resHi;
              r_lo <= w_resLo;
            end
          end else if (flush) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
